// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests, turns an exception into a
// registered one-cycle flush with redirect PC, and keeps watchdog/stall/flush counters.
module pipe_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int STALL_LIMIT = 1023,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_target_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int WD_W = $clog2(STALL_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_LIMIT);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t              state_r;
  logic                flush_r;
  logic [ADDR_W-1:0]   new_pc_r;
  logic                stall_timeout_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [15:0]         flush_cnt_r;
  logic [WD_W-1:0]     wd_cnt_r;
  logic [5:0]          stall_s;
  logic                stall_busy_s;

  // Returns 1 when a counter value is at its all-ones ceiling.
  function automatic logic sat16(input logic [15:0] v);
    return (v == 16'hFFFF);
  endfunction

  // Priority merge of stall requests; the pipe is never held while an exception
  // is pending or being flushed, and held at zero while in reset.
  always_comb begin
    stall_s = 6'b000000;
    if (rst || (state_r != RUN) || excp_valid) begin
      stall_s = 6'b000000;
    end else if (stallreq_mem) begin
      stall_s = 6'b011111;
    end else if (stallreq_ex) begin
      stall_s = 6'b001111;
    end else if (stallreq_id) begin
      stall_s = 6'b000111;
    end else begin
      stall_s = 6'b000000;
    end
  end

  assign stall_busy_s = |stall_s;

  // Exception sequencer: one FLUSH cycle per accepted exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      flush_r     <= 1'b0;
      new_pc_r    <= '0;
      flush_cnt_r <= 16'h0000;
    end else begin
      case (state_r)
        RUN: begin
          if (excp_valid) begin
            state_r  <= FLUSH;
            flush_r  <= 1'b1;
            new_pc_r <= excp_target_pc;
          end else begin
            flush_r  <= 1'b0;
          end
        end
        FLUSH: begin
          state_r <= RUN;
          flush_r <= 1'b0;
          if (!sat16(flush_cnt_r)) begin
            flush_cnt_r <= flush_cnt_r + 16'h0001;
          end
        end
        default: begin
          state_r <= RUN;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any stage was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (stall_busy_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Watchdog: consecutive stalled cycles; the timeout flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r        <= '0;
      stall_timeout_r <= 1'b0;
    end else if (!stall_busy_s) begin
      wd_cnt_r <= '0;
    end else if (wd_cnt_r < WD_LIMIT) begin
      wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
      if ((wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1}) == WD_LIMIT) begin
        stall_timeout_r <= 1'b1;
      end else begin
        stall_timeout_r <= stall_timeout_r;
      end
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  assign stall         = stall_s;
  assign flush         = flush_r;
  assign new_pc        = new_pc_r;
  assign stall_timeout = stall_timeout_r;
  assign stall_cnt     = stall_cnt_r;
  assign flush_cnt     = flush_cnt_r;

endmodule
